// File: rtl/ascii_line_tx.sv
// ascii_line_tx: streams a 4-char field, then an end-of-line, to a UART TX.
// Optional feature macro: ASCII_TX_CRLF_EN (CR before EOL_CHAR when defined).
module ascii_line_tx #(
  parameter bit          SKIP_NUL = 1'b1,
  parameter logic [7:0]  EOL_CHAR = 8'h0A,
  parameter logic [7:0]  CR_CHAR  = 8'h0D,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       ch0,
  input  logic [7:0]       ch1,
  input  logic [7:0]       ch2,
  input  logic [7:0]       ch3,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

  // LOAD: moving slot idx into the output register.
  // SEND: slots done, first terminator byte pending.
  // CR/EOL: that terminator byte sits in the output register.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
`ifdef ASCII_TX_CRLF_EN
    CR,
`endif
    EOL
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;
  logic [7:0]       slot_q [4];
  logic [7:0]       slot_d [4];
  logic [7:0]       data_q;
  logic [7:0]       data_d;
  logic             valid_q;
  logic             valid_d;
  logic             busy_q;
  logic             busy_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic free;
  logic skip;

  // The output register can take a new byte when empty or being handed off.
  assign free = !valid_q || tx_ready;
  assign skip = SKIP_NUL && (slot_q[idx_q] == 8'h00);

  assign in_ready    = (state_q == IDLE);
  assign tx_data     = data_q;
  assign tx_valid    = valid_q;
  assign busy        = busy_q;
  assign frame_count = cnt_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    slot_d  = slot_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          slot_d[0] = ch0;
          slot_d[1] = ch1;
          slot_d[2] = ch2;
          slot_d[3] = ch3;
          idx_d     = 2'd0;
          busy_d    = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (free) begin
          if (skip) begin
            valid_d = 1'b0;
          end else begin
            data_d  = slot_q[idx_q];
            valid_d = 1'b1;
          end
          if (idx_q == 2'd3) begin
            state_d = SEND;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      SEND: begin
        if (free) begin
          valid_d = 1'b1;
`ifdef ASCII_TX_CRLF_EN
          data_d  = CR_CHAR;
          state_d = CR;
`else
          data_d  = EOL_CHAR;
          state_d = EOL;
`endif
        end
      end
`ifdef ASCII_TX_CRLF_EN
      CR: begin
        if (tx_ready) begin
          data_d  = EOL_CHAR;
          state_d = EOL;
        end
      end
`endif
      EOL: begin
        if (tx_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = cnt_q + CNT_ONE;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any frame in progress.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      slot_q  <= '{default: 8'h00};
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ascii_line_tx.sv
// tb_ascii_line_tx: directed vector bench for ascii_line_tx.
// frame_count is built 2 bits wide so wrap-around is reached quickly.
module tb_ascii_line_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] ch0, ch1, ch2, ch3;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic [1:0] frame_count;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] c    [4];
    logic [7:0] body [4];
    int         nbody;
    int         lat;
    int         cnt;
  } vec_t;

  vec_t tbl [5];

  ascii_line_tx #(.CNT_W(2)) dut (
    .clock       (clk),
    .reset_n     (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ch0         (ch0),
    .ch1         (ch1),
    .ch2         (ch2),
    .ch3         (ch3),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [7:0] c [4]);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk("in_ready before accept", int'(in_ready), 1);
    in_valid = 1'b1;
    ch0 = c[0];
    ch1 = c[1];
    ch2 = c[2];
    ch3 = c[3];
    step();
    in_valid = 1'b0;
    ch0 = 8'($urandom);
    ch1 = 8'($urandom);
    ch2 = 8'($urandom);
    ch3 = 8'($urandom);
    chk("busy after accept", int'(busy), 1);
    chk("in_ready after accept", int'(in_ready), 0);
  endtask

  task automatic expect_stream(input logic [7:0] body [4],
                               input int nbody, input int lat);
    logic [7:0] e [6];
    int ne, got, cyc;
    ne = 0;
    for (int i = 0; i < nbody; i++) begin
      e[ne] = body[i];
      ne++;
    end
`ifdef ASCII_TX_CRLF_EN
    e[ne] = 8'h0D;
    ne++;
`endif
    e[ne] = 8'h0A;
    ne++;
    got = 0;
    cyc = 0;
    while (got < ne && cyc < 24) begin
      step();
      cyc++;
      if (tx_valid) begin
        if (got == 0) chk("first byte latency", cyc, lat);
        chk("stream byte", int'(tx_data), int'(e[got]));
        got++;
      end
    end
    if (got < ne) chk("stream timeout bytes", got, ne);
  endtask

  task automatic finish_check(input int cnt);
    step();
    chk("busy after eol", int'(busy), 0);
    chk("tx_valid after eol", int'(tx_valid), 0);
    chk("in_ready after eol", int'(in_ready), 1);
    chk("frame_count", int'(frame_count), cnt);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{'{8'h2D, 8'h31, 8'h30, 8'h30},
               '{8'h2D, 8'h31, 8'h30, 8'h30}, 4, 1, 1};
    tbl[1] = '{'{8'h00, 8'h30, 8'h34, 8'h32},
               '{8'h30, 8'h34, 8'h32, 8'h00}, 3, 2, 2};
    tbl[2] = '{'{8'h2B, 8'h39, 8'h39, 8'h39},
               '{8'h2B, 8'h39, 8'h39, 8'h39}, 4, 1, 3};
    tbl[3] = '{'{8'h20, 8'h00, 8'h37, 8'h00},
               '{8'h20, 8'h37, 8'h00, 8'h00}, 2, 1, 0};
    tbl[4] = '{'{8'h00, 8'h00, 8'h00, 8'h35},
               '{8'h35, 8'h00, 8'h00, 8'h00}, 1, 4, 1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    tx_ready = 1'b1;
    ch0 = 8'h00;
    ch1 = 8'h00;
    ch2 = 8'h00;
    ch3 = 8'h00;
    step();
    step();
    rst_n = 1'b1;
    chk("reset tx_valid", int'(tx_valid), 0);
    chk("reset tx_data", int'(tx_data), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset frame_count", int'(frame_count), 0);
    chk("reset in_ready", int'(in_ready), 1);

    for (int i = 0; i < 5; i++) begin
      accept(tbl[i].c);
      expect_stream(tbl[i].body, tbl[i].nbody, tbl[i].lat);
      finish_check(tbl[i].cnt);
    end

    // Stall on '1', with a competing field offered mid-frame.
    v = tbl[0];
    accept(v.c);
    step();
    chk("stall pre 2D", int'(tx_data), 8'h2D);
    step();
    chk("stall pre 31", int'(tx_data), 8'h31);
    tx_ready = 1'b0;
    in_valid = 1'b1;
    ch0 = 8'h2B;
    ch1 = 8'h38;
    ch2 = 8'h38;
    ch3 = 8'h38;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall tx_valid", int'(tx_valid), 1);
      chk("stall tx_data", int'(tx_data), 8'h31);
      chk("stall in_ready", int'(in_ready), 0);
    end
    tx_ready = 1'b1;
    step();
    chk("resume 30a", int'(tx_data), 8'h30);
    step();
    chk("resume 30b", int'(tx_data), 8'h30);
`ifdef ASCII_TX_CRLF_EN
    step();
    chk("resume cr", int'(tx_data), 8'h0D);
`endif
    step();
    chk("resume eol", int'(tx_data), 8'h0A);
    chk("resume eol valid", int'(tx_valid), 1);
    finish_check(2);
    step();
    in_valid = 1'b0;
    chk("late field busy", int'(busy), 1);
    chk("late field in_ready", int'(in_ready), 0);
    v.body[0] = 8'h2B;
    v.body[1] = 8'h38;
    v.body[2] = 8'h38;
    v.body[3] = 8'h38;
    expect_stream(v.body, 4, 1);
    finish_check(3);

    // Reset while the third byte is pending.
    v.c[0] = 8'h2D;
    v.c[1] = 8'h31;
    v.c[2] = 8'h32;
    v.c[3] = 8'h33;
    accept(v.c);
    step();
    step();
    step();
    chk("pre reset byte3", int'(tx_data), 8'h32);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid reset tx_valid", int'(tx_valid), 0);
    chk("mid reset tx_data", int'(tx_data), 0);
    chk("mid reset busy", int'(busy), 0);
    chk("mid reset frame_count", int'(frame_count), 0);
    chk("mid reset in_ready", int'(in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post reset quiet", int'(tx_valid), 0);
    end
    accept(tbl[0].c);
    expect_stream(tbl[0].body, tbl[0].nbody, tbl[0].lat);
    finish_check(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
